// File: rtl/upsample_nn_if.sv
// Pixel stream bundle for the nearest-neighbour unpooling block.
// The input side is valid/ready; the output side is valid-only with a frame-end marker.
interface upsample_nn_if #(
    parameter int BW = 20
);
    logic [BW-1:0] i_data;
    logic          i_valid;
    logic          i_ready;
    logic [BW-1:0] o_data;
    logic          o_valid;
    logic          o_end;

    modport master (
        output i_data, i_valid,
        input  i_ready, o_data, o_valid, o_end
    );
    modport slave (
        input  i_data, i_valid,
        output i_ready, o_data, o_valid, o_end
    );
endinterface

// File: rtl/upsample_nn.sv
// Nearest-neighbour unpooling: each input pixel becomes a P_SIZE x P_SIZE block.
// One input row is captured in FILL while it is emitted, then REPLAY repeats it P_SIZE-1 times.
module upsample_nn #(
    parameter int BW     = 20,
    parameter int I_SIZE = 24,
    parameter int O_SIZE = 12,
    parameter int P_SIZE = 2
) (
    input logic          clk,
    input logic          rst,
    input logic          user_reset,
    upsample_nn_if.slave s
);
    localparam int CW = $clog2(O_SIZE) + 1;
    localparam int RW = $clog2(P_SIZE) + 1;
    localparam int IW = (O_SIZE > 1) ? $clog2(O_SIZE) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(O_SIZE - 1);
    localparam logic [CW-1:0] COL_FULL = CW'(O_SIZE);
    localparam logic [RW-1:0] REP_LAST = RW'(P_SIZE - 1);
    // P_SIZE-2 is both the final replay pass and the copy just before the last one.
    localparam logic [RW-1:0] REP_PEN  = RW'(P_SIZE - 2);

    if (I_SIZE != O_SIZE * P_SIZE) begin : g_size_chk
        $error("upsample_nn: I_SIZE must equal O_SIZE*P_SIZE");
    end

    typedef enum logic {FILL, REPLAY} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] col_q, col_d, row_q, row_d, col_inc, row_nxt;
    logic [RW-1:0] rep_q, rep_d, pass_q, pass_d;
    logic [BW-1:0] o_data_q, o_data_d;
    logic          o_valid_q, o_valid_d, o_end_q, o_end_d;
    logic          ready, accept, row_last;
    logic [BW-1:0] row_buf_q [2**IW];

    assign col_inc  = col_q + 1'b1;
    assign row_last = (row_q == COL_LAST);
    assign row_nxt  = row_last ? '0 : row_q + 1'b1;
    // A new pixel may be taken once the presented one is on its final copy.
    assign ready    = (state_q == FILL) &&
                      (!o_valid_q || (rep_q == REP_LAST && col_q < COL_FULL));
    assign accept   = s.i_valid && ready;

    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        row_d     = row_q;
        rep_d     = rep_q;
        pass_d    = pass_q;
        o_data_d  = o_data_q;
        o_valid_d = 1'b0;
        o_end_d   = 1'b0;
        unique case (state_q)
            FILL: begin
                if (accept) begin
                    o_data_d  = s.i_data;
                    o_valid_d = 1'b1;
                    rep_d     = '0;
                    if (P_SIZE == 1 && col_q == COL_LAST) begin
                        col_d   = '0;
                        row_d   = row_nxt;
                        o_end_d = row_last;
                    end else begin
                        col_d = col_inc;
                    end
                end else if (o_valid_q && rep_q != REP_LAST) begin
                    o_valid_d = 1'b1;
                    rep_d     = rep_q + 1'b1;
                end else if (o_valid_q && col_q == COL_FULL) begin
                    state_d   = REPLAY;
                    col_d     = '0;
                    rep_d     = '0;
                    pass_d    = '0;
                    o_data_d  = row_buf_q[0];
                    o_valid_d = 1'b1;
                end
            end
            REPLAY: begin
                o_valid_d = 1'b1;
                if (rep_q != REP_LAST) begin
                    rep_d = rep_q + 1'b1;
                    // The row's final beat is presented from FILL so the next row can start under it.
                    if (pass_q == REP_PEN && col_q == COL_LAST && rep_q == REP_PEN) begin
                        state_d = FILL;
                        col_d   = '0;
                        row_d   = row_nxt;
                        o_end_d = row_last;
                    end
                end else if (col_q != COL_LAST) begin
                    rep_d    = '0;
                    col_d    = col_inc;
                    o_data_d = row_buf_q[col_inc[IW-1:0]];
                end else begin
                    rep_d    = '0;
                    col_d    = '0;
                    pass_d   = pass_q + 1'b1;
                    o_data_d = row_buf_q[0];
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || user_reset) begin
            state_q   <= FILL;
            col_q     <= '0;
            row_q     <= '0;
            rep_q     <= '0;
            pass_q    <= '0;
            o_data_q  <= '0;
            o_valid_q <= 1'b0;
            o_end_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            row_q     <= row_d;
            rep_q     <= rep_d;
            pass_q    <= pass_d;
            o_data_q  <= o_data_d;
            o_valid_q <= o_valid_d;
            o_end_q   <= o_end_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) row_buf_q[col_q[IW-1:0]] <= s.i_data;
    end

    assign s.i_ready = ready;
    assign s.o_data  = o_data_q;
    assign s.o_valid = o_valid_q;
    assign s.o_end   = o_end_q;
endmodule

// File: doc/upsample_nn.md
Name: upsample_nn

Overview:
- Nearest-neighbour unpooling block: the inverse of the 2x2 max-pool stage.
- Accepts an O_SIZE x O_SIZE feature map as a raster pixel stream and emits an I_SIZE x I_SIZE raster stream.
- Each input pixel becomes a P_SIZE x P_SIZE block of identical outputs.
- Sits in the decoder/reconstruction path of the feature pipeline, one instance per channel. A single-row buffer replays each row P_SIZE-1 more times.

Parameters:
- BW, 20, pixel data width.
- I_SIZE, 24, output map width/height; must equal O_SIZE*P_SIZE.
- O_SIZE, 12, input map width/height.
- P_SIZE, 2, upsampling factor (>=1).

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous active-high reset
- user_reset  input  1  synchronous active-high soft clear, same effect as rst
- i_data  input  BW  input pixel
- i_valid  input  1  i_data valid
- i_ready  output  1  block accepts i_data this cycle (transfer = i_valid && i_ready)
- o_data  output  BW  output pixel, registered
- o_valid  output  1  o_data valid this cycle; downstream always accepts, no backpressure
- o_end  output  1  one-cycle pulse coincident with the last output beat of a frame

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- rst or user_reset at a clock edge (highest priority, including mid-frame) forces:
  - o_valid=0, o_end=0, o_data=0.
  - State FILL; column, row and repeat counters = 0.
  - Row buffer contents don't-care.
- The next frame starts fresh at row 0, col 0.
- States:
  - FILL: accept one input row.
  - REPLAY: re-emit the buffered row.
- FILL:
  - i_ready = 1 when no pixel is pending, or when the pending pixel is on its last copy (rep == P_SIZE-1) and col < O_SIZE.
  - i_ready is combinational from state/counters only, never from i_valid.
  - A pixel accepted at edge k is written to buffer[col] and appears on o_data with o_valid=1 for exactly P_SIZE consecutive cycles, starting the cycle after edge k.
  - Back-to-back acceptance gives a gapless output row. If i_valid is low when a new pixel could be taken, o_valid drops to 0 (bubble) until the next transfer.
  - After the last copy of column O_SIZE-1: if P_SIZE==1, go to the row-end check; otherwise go to REPLAY.
- REPLAY:
  - i_ready=0.
  - Emits buffer[0..O_SIZE-1], each P_SIZE consecutive beats, with o_valid=1 every cycle and no gaps.
  - Repeats the row pass P_SIZE-1 times.
  - The first replay beat directly follows the last FILL beat.
- Row-end check: if row == O_SIZE-1, assert o_end on that final beat, then row=0; otherwise row+1. Return to FILL.
- Counter widths: col and row counters clog2(O_SIZE)+1 bits; repeat counters clog2(P_SIZE)+1 bits. All wrap exactly at their terminal value.
- Per frame: exactly I_SIZE*I_SIZE o_valid beats and exactly one o_end pulse.
- The next frame's first pixel may be accepted on the cycle the o_end beat is presented, or later.
- No arithmetic on pixel data: o_data is a bit-exact copy of i_data.
- o_end is never asserted while o_valid=0.

Test Plan:
- Config BW=8, O_SIZE=2, P_SIZE=2, I_SIZE=4; stream 1,2,3,4 with i_valid held high -> o_data rows 1,1,2,2 / 1,1,2,2 / 3,3,4,4 / 3,3,4,4, 16 contiguous beats within each FILL+REPLAY span; o_end only on beat 16; i_ready low throughout REPLAY.
- Same config, i_valid low for 3 cycles before pixel 2 -> 3 bubble cycles (o_valid=0) between the copies of 1 and 2; data sequence unchanged; replay row still gapless.
- Default config, two frames back-to-back with random data -> 576 beats per frame; each output pixel (r,c) equals input (r/2,c/2); one o_end per frame; second frame starts at row 0.
- Assert rst mid-REPLAY of row 5, then stream a new frame -> next cycle o_valid=0, o_end=0, i_ready=1; new frame output correct from pixel (0,0). Repeat the test with user_reset.
- P_SIZE=1, O_SIZE=I_SIZE=4: output equals input stream with 1-cycle latency; i_ready tracks per pixel; o_end on the 16th beat.
- Hold i_valid=1 with i_data changing during REPLAY -> no pixels consumed; sequence resumes with the next accepted value after return to FILL.
